// File: rtl/popcount_accumulator_pkg.sv
// Shared constants for the binary-conv popcount path.
// The accumulator width defaults are kept here so the requant stage sizes itself identically.
package popcount_accumulator_pkg;

    // Width of a per-beat ones count (0..12 fits in 4 bits)
    localparam int CNT_W        = 4;
    // Bits per input beat, which is also the largest per-beat count
    localparam int MAX_BEAT_CNT = 12;
    // Default group-sum width
    localparam int ACC_W_DEF    = 16;
    // Default beat-counter width
    localparam int LEN_W_DEF    = 8;

endpackage

// File: rtl/popcount_accumulator_adder.sv
// 12-input ones counter: purely combinational, {O3,O2,O1,O0} = number of set bits.
module adder_12to4
    import popcount_accumulator_pkg::*;
(
    input  logic [MAX_BEAT_CNT-1:0] i_bits,
    output logic [CNT_W-1:0]        o_cnt
);

    logic [CNT_W-1:0] w_sum;

    // Ripple sum of the twelve bits; synthesis reduces this to a compressor tree
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < MAX_BEAT_CNT; i++) begin
            w_sum = w_sum + {{(CNT_W-1){1'b0}}, i_bits[i]};
        end
    end

    assign o_cnt = w_sum;

endmodule

// File: rtl/popcount_accumulator.sv
// Streaming popcount accumulator: counts set bits per beat, sums them over a group closed
// by in_last, and emits one saturated result per group through a valid/ready output.
module popcount_accumulator
    import popcount_accumulator_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MAX_BEAT_CNT-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_sum,
    output logic [LEN_W-1:0]        out_beats,
    output logic                    out_ovf
);

    // Clamp an ACC_W+1 bit sum to the ACC_W range
    function automatic logic [ACC_W-1:0] sat_sum(input logic [ACC_W:0] s);
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    // Increment the beat counter, sticking at its maximum
    function automatic logic [LEN_W-1:0] sat_beat(input logic [LEN_W-1:0] b);
        return (b == {LEN_W{1'b1}}) ? b : b + {{(LEN_W-1){1'b0}}, 1'b1};
    endfunction

    logic [CNT_W-1:0] w_cnt_p0;
    logic             w_out_free;
    logic             w_s1_stall;
    logic             w_accept;
    logic             w_fire;
    logic [ACC_W:0]   w_nsum;
    logic             w_sat;
    logic [ACC_W-1:0] w_sum_sat;
    logic [LEN_W-1:0] w_nbeat;

    logic [CNT_W-1:0] r_cnt_p1;
    logic             r_last_p1;
    logic             r_vld_p1;

    logic [ACC_W-1:0] r_acc;
    logic [LEN_W-1:0] r_beat_cnt;
    logic             r_acc_ovf;

    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_sum;
    logic [LEN_W-1:0] r_out_beats;
    logic             r_out_ovf;

    // ---- stage 0: combinational ones count ahead of the S1 register ----
    adder_12to4 u_adder (
        .i_bits (in_data),
        .o_cnt  (w_cnt_p0)
    );

    // Only a last beat needs the output register; non-last beats always drain into acc
    assign w_out_free = !r_out_valid || out_ready;
    assign w_s1_stall = r_vld_p1 && r_last_p1 && !w_out_free;
    assign in_ready   = !r_vld_p1 || !(r_last_p1 && !w_out_free);
    assign w_accept   = in_valid && in_ready;
    assign w_fire     = r_vld_p1 && !w_s1_stall;

    // S1 control: valid set on accept, cleared once the beat is consumed by stage 2
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
        end else if (w_accept) begin
            r_vld_p1 <= 1'b1;
        end else if (w_fire) begin
            r_vld_p1 <= 1'b0;
        end
    end

    // S1 data: captured only on accept so an undriven in_data never enters the pipe
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_cnt_p1  <= w_cnt_p0;
            r_last_p1 <= in_last;
        end
    end

    // ---- stage 1 -> stage 2: accumulate with saturation ----
    assign w_nsum    = {1'b0, r_acc} + {{(ACC_W+1-CNT_W){1'b0}}, r_cnt_p1};
    assign w_sat     = w_nsum[ACC_W];
    assign w_sum_sat = sat_sum(w_nsum);
    assign w_nbeat   = sat_beat(r_beat_cnt);

    // Group accumulator: beat_cnt==0 is the implicit idle state, cleared when a group closes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_acc_ovf  <= 1'b0;
        end else if (w_fire) begin
            if (r_last_p1) begin
                r_acc      <= '0;
                r_beat_cnt <= '0;
                r_acc_ovf  <= 1'b0;
            end else begin
                r_acc      <= w_sum_sat;
                r_beat_cnt <= w_nbeat;
                r_acc_ovf  <= r_acc_ovf | w_sat;
            end
        end
    end

    // ---- stage 2 -> output register ----
    // Result register: a reload in the same cycle as a handshake wins, avoiding a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_beats <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_fire && r_last_p1) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum_sat;
            r_out_beats <= w_nbeat;
            r_out_ovf   <= r_acc_ovf | w_sat;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_beats = r_out_beats;
    assign out_ovf   = r_out_ovf;

endmodule
